// File: rtl/instruction_decode_pkg.sv
// -----------------------------------------------------------------------------
// instruction_decode_pkg
// Shared definitions for the instruction decode stage: FSM state encoding,
// opcode class constants and a small helper that forms the short immediate
// carried by non-LDI instructions.
// -----------------------------------------------------------------------------
package instruction_decode_pkg;

  // Decode FSM states (2-bit encoding, value 3 unused)
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IMM = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  // Opcode class field, opcode[7:6]
  localparam logic [1:0] CLASS_ALU   = 2'b00;
  localparam logic [1:0] CLASS_LOAD  = 2'b01;
  localparam logic [1:0] CLASS_STORE = 2'b10;
  localparam logic [1:0] CLASS_LDI   = 2'b11;

  // Non-LDI instructions carry their rs field zero-extended as the immediate
  function automatic logic [7:0] short_imm(input logic [7:0] opcode);
    short_imm = {5'b00000, opcode[2:0]};
  endfunction

endpackage : instruction_decode_pkg

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// Byte-serial instruction decoder between a fetch stage and an execute stage.
// An opcode byte is taken from fetch with a one-cycle ack_prev pulse. ALU,
// LOAD and STORE opcodes are decoded at once; LDI opcodes wait for a second
// immediate byte. The decoded instruction is then presented with DOR until the
// execute stage acknowledges it, at which point decode_count advances.
//
// Ports
//   clk           in   1  clock, all state changes on rising edge
//   reset         in   1  synchronous, active-high reset
//   DIR           in   1  fetch stage has a valid byte on data_in
//   data_in       in   8  opcode or immediate byte
//   ack_prev      out  1  one-cycle pulse: data_in byte consumed
//   DOR           out  1  decoded instruction valid toward execute
//   ack_from_next in   1  execute stage has taken the instruction
//   op_class      out  2  opcode[7:6]
//   rd            out  3  opcode[5:3]
//   rs            out  3  opcode[2:0], 0 for LDI
//   imm           out  8  LDI second byte, else {5'b0, opcode[2:0]}
//   decode_count  out  8  instructions handed downstream (wraps)
// -----------------------------------------------------------------------------
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       DIR,
  input  logic [7:0] data_in,
  output logic       ack_prev,
  output logic       DOR,
  input  logic       ack_from_next,
  output logic [1:0] op_class,
  output logic [2:0] rd,
  output logic [2:0] rs,
  output logic [7:0] imm,
  output logic [7:0] decode_count
);

  state_e     state_r,    state_s;
  logic       ack_prev_r, ack_prev_s;
  logic       dor_r,      dor_s;
  logic [1:0] op_class_r, op_class_s;
  logic [2:0] rd_r,       rd_s;
  logic [2:0] rs_r,       rs_s;
  logic [7:0] imm_r,      imm_s;
  logic [7:0] count_r,    count_s;

  // A byte is only taken when ack_prev is low, so a DIR that lingers for the
  // cycle after a handshake is never captured a second time.
  logic take_byte_s;
  assign take_byte_s = DIR & ~ack_prev_r;

  // State and output registers, synchronous reset has top priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ack_prev_r <= 1'b0;
      dor_r      <= 1'b0;
      op_class_r <= 2'b00;
      rd_r       <= 3'b000;
      rs_r       <= 3'b000;
      imm_r      <= 8'h00;
      count_r    <= 8'h00;
    end else begin
      state_r    <= state_s;
      ack_prev_r <= ack_prev_s;
      dor_r      <= dor_s;
      op_class_r <= op_class_s;
      rd_r       <= rd_s;
      rs_r       <= rs_s;
      imm_r      <= imm_s;
      count_r    <= count_s;
    end
  end

  // Next-state and next-output logic; everything holds unless a case changes it
  always_comb begin
    state_s    = state_r;
    ack_prev_s = 1'b0;
    dor_s      = dor_r;
    op_class_s = op_class_r;
    rd_s       = rd_r;
    rs_s       = rs_r;
    imm_s      = imm_r;
    count_s    = count_r;

    case (state_r)
      IDLE: begin
        if (take_byte_s) begin
          ack_prev_s = 1'b1;
          op_class_s = data_in[7:6];
          rd_s       = data_in[5:3];
          if (data_in[7:6] == CLASS_LDI) begin
            // Immediate arrives as the next byte; nothing valid downstream yet
            rs_s    = 3'b000;
            imm_s   = 8'h00;
            state_s = WAIT_IMM;
          end else begin
            rs_s    = data_in[2:0];
            imm_s   = short_imm(data_in);
            dor_s   = 1'b1;
            state_s = WAIT_ACK;
          end
        end else begin
          state_s = IDLE;
        end
      end

      WAIT_IMM: begin
        if (take_byte_s) begin
          ack_prev_s = 1'b1;
          imm_s      = data_in;
          dor_s      = 1'b1;
          state_s    = WAIT_ACK;
        end else begin
          state_s = WAIT_IMM;
        end
      end

      WAIT_ACK: begin
        // Backpressure: fetch is not acknowledged while an instruction is pending
        if (ack_from_next) begin
          dor_s   = 1'b0;
          count_s = count_r + 8'd1;
          state_s = IDLE;
        end else begin
          state_s = WAIT_ACK;
        end
      end

      default: begin
        state_s = IDLE;
        dor_s   = 1'b0;
      end
    endcase
  end

  assign ack_prev     = ack_prev_r;
  assign DOR          = dor_r;
  assign op_class     = op_class_r;
  assign rd           = rd_r;
  assign rs           = rs_r;
  assign imm          = imm_r;
  assign decode_count = count_r;

endmodule : instruction_decode
